// File: rtl/apb_uart_tx32.sv
// UART transmitter fed by the APB UART slave: one start bit, DATA_BITS data bits LSB first, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module apb_uart_tx32 #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int DATA_BITS    = 32
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        start,
    input  logic [31:0] To_TX,
    output logic        tx_serial,
    output logic        tx_busy,
    output logic        Tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   bit_end;

    assign bit_end = (cnt_reg == CNT_LAST);

    // Outputs are registered alongside the state, so each transition loads the line
    // level that belongs to the bit being entered.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            Tx_done   <= 1'b0;
        end else begin
            Tx_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    cnt_reg   <= '0;
                    idx_reg   <= '0;
                    if (start) begin
                        shift_reg <= To_TX[DATA_BITS-1:0];
                        state_reg <= START;
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= DATA;
                        tx_serial <= shift_reg[0];
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (idx_reg == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_reg <= PARITY;
                            tx_serial <= ^shift_reg;
`else
                            state_reg <= STOP;
                            tx_serial <= 1'b1;
`endif
                        end else begin
                            idx_reg   <= idx_reg + IDX_W'(1);
                            tx_serial <= shift_reg[idx_reg + IDX_W'(1)];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        state_reg <= STOP;
                        tx_serial <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        idx_reg <= '0;
                        // A request on the final stop cycle chains straight into the next frame.
                        if (start) begin
                            shift_reg <= To_TX[DATA_BITS-1:0];
                            state_reg <= START;
                            tx_serial <= 1'b0;
                            tx_busy   <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            tx_serial <= 1'b1;
                            tx_busy   <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_DONE) begin
                            Tx_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_uart_tx32.md
Name: apb_uart_tx32

Overview:
- Serial transmitter directly downstream of the APB UART slave (slave1).
- Consumes the slave's `start` strobe and 32-bit `To_TX` word.
- Emits one asynchronous UART frame per word: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
- Reports `tx_busy` and a one-cycle `Tx_done` so the slave or software can pace writes.

Parameters:
- CLKS_PER_BIT, 1042, PCLK cycles per serial bit (10 MHz PCLK / 9600 baud); legal range >= 2.
- DATA_BITS, 32, data bits per frame; legal range 8..32; frame carries To_TX[DATA_BITS-1:0].

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- PRESETn  input  1  reset, asynchronous assert, active-low.
- start  input  1  transmit request from the APB slave, level or pulse.
- To_TX  input  32  word to transmit; sampled only when a request is accepted.
- tx_serial  output  1  UART line, idle high; registered.
- tx_busy  output  1  high while a frame is in progress; registered.
- Tx_done  output  1  one-cycle pulse on the last cycle of the stop bit; registered.

Behaviour:
- Reset: one clock (PCLK); reset PRESETn is asynchronous and active-low. While low, all of the following hold:
  - state = IDLE, tx_serial = 1, tx_busy = 0, Tx_done = 0, counters = 0, shift register = 0.
  - Reset mid-frame aborts the frame immediately; there is no partial stop bit.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - tx_serial = 1.
  - On a rising edge with start = 1: latch To_TX into the shift register, clear baud counter, go to START.
  - tx_busy = 1 from the next cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1. Every bit is driven for exactly CLKS_PER_BIT cycles.
  - Counter width = $clog2(CLKS_PER_BIT).
  - Bit index width = $clog2(DATA_BITS).
- START: tx_serial = 0 for one bit time, then go to DATA with bit index = 0.
- DATA:
  - tx_serial = shift[bit index].
  - At end of each bit time, bit index increments.
  - After bit DATA_BITS-1, go to PARITY if compiled in, else STOP.
- STOP:
  - tx_serial = 1 for one bit time.
  - On the last cycle of the bit, Tx_done = 1 for exactly that cycle.
  - Next state is IDLE; tx_busy drops the cycle after.
- Back-to-back: if start = 1 on the last STOP cycle, the new To_TX is latched and START is entered directly.
  - No idle cycle is inserted; tx_busy stays high; Tx_done still pulses.
- start while busy (any other cycle): ignored, not queued. To_TX changes while busy do not affect the frame in flight.
- Latency:
  - start edge to tx_serial falling: 1 cycle.
  - Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles, or +CLKS_PER_BIT with parity.
- Width rule: To_TX bits above DATA_BITS-1 are ignored.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, one bit time.
  - tx_serial = XOR of the transmitted data bits (even parity).
  - Frame = (DATA_BITS+3)*CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state or logic exists.
  - DATA goes straight to STOP; frame = (DATA_BITS+2)*CLKS_PER_BIT.

Test Plan:
- Reset/idle: PRESETn = 0 for 3 cycles, then 1, start = 0 -> tx_serial = 1, tx_busy = 0, Tx_done = 0 throughout.
- Single frame (CLKS_PER_BIT=4, DATA_BITS=32): start one cycle with To_TX = 32'hA5C3_0F01.
  - tx_serial low cycles 1..4, then bits 1,0,0,0,0,0,0,0,1,1,1,1,... each 4 cycles, stop high.
  - Tx_done pulses once at cycle 136; tx_busy high cycles 1..136.
  - Sampled bits reassemble to A5C3_0F01.
- Ignored request: start pulses with To_TX = 32'h1234_5678 mid-DATA of a frame carrying 32'hFFFF_FFFF.
  - Frame still carries FFFF_FFFF; no second frame follows.
  - Exactly one Tx_done pulse.
- Back-to-back: start held high across two frames, To_TX = 32'h0000_0001 then 32'h8000_0000 (changed after first accept).
  - Second start bit begins the cycle after the first Tx_done; no idle-high gap beyond the stop bit.
- Reset mid-frame: PRESETn = 0 during DATA bit 10.
  - Same cycle: tx_serial = 1, tx_busy = 0.
  - After release: no Tx_done; next start sends a full clean frame.
- Parity (UART_TX_PARITY_EN defined): To_TX = 32'h0000_0007 -> parity bit = 1 for 4 cycles before stop, Tx_done at cycle 140.
  - With 32'h0000_0003 -> parity bit = 0.
